// File: rtl/led_scan_ctrl.sv
// Row-scan scheduler for an LED matrix: double-buffered frame, blank-then-on row slots,
// and frame-boundary buffer swaps under a swap_req/swap_ack handshake.
module led_scan_ctrl #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned DWELL = 256,
    parameter int unsigned BLANK = 4,
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            divided_clk,
    input  logic            rst,
    input  logic            en,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap_req,
    output logic            swap_ack,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col,
    output logic [RW-1:0]   cur_row,
    output logic            frame_start
);

    localparam int unsigned CW = $clog2(DWELL);
    localparam logic [CW-1:0] BlankEnd = CW'(BLANK - 1);
    localparam logic [CW-1:0] DwellEnd = CW'(DWELL - 1);
    localparam logic [RW-1:0] LastRow  = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StOn
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic            front_q, front_d;
    logic            boundary;
    logic            swap_do;
    logic            wr_ok;
    logic [COLS-1:0] bufs_q [2][ROWS];

    logic [ROWS-1:0] row_sel_d;
    logic [COLS-1:0] col_d;
    logic            frame_start_d;
    logic            swap_ack_d;

    // State register
    always_ff @(posedge divided_clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        boundary = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            StBlank: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BlankEnd) begin
                        state_d = StOn;
                    end
                end
            end
            StOn: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    row_d   = '0;
                end else if (cnt_q == DwellEnd) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    if (row_q == LastRow) begin
                        row_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    // A swap is only ever taken when the next cycle is blanked or idle, so the
    // new front buffer is never read on the swap edge itself.
    assign swap_do = swap_req && ((state_q == StIdle) || boundary);
    assign front_d = front_q ^ swap_do;

    if ((1 << RW) == ROWS) begin : g_pow2
        assign wr_ok = wr_en;
    end else begin : g_npow2
        assign wr_ok = wr_en && (32'(wr_row) < ROWS);
    end

    // Output logic, computed from the next state so every output is registered
    always_comb begin
        row_sel_d     = '0;
        col_d         = '0;
        frame_start_d = (state_d == StBlank) && (cnt_d == '0) && (row_d == '0);
        swap_ack_d    = swap_do;
        if (state_d == StOn) begin
            row_sel_d = ROWS'(1) << row_d;
            col_d     = bufs_q[front_q][row_d];
        end
    end

    always_ff @(posedge divided_clk) begin
        if (rst) begin
            cnt_q       <= '0;
            row_q       <= '0;
            front_q     <= 1'b0;
            row_sel     <= '0;
            col         <= '0;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            for (int i = 0; i < int'(ROWS); i++) begin
                bufs_q[0][i] <= '0;
                bufs_q[1][i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            front_q     <= front_d;
            row_sel     <= row_sel_d;
            col         <= col_d;
            frame_start <= frame_start_d;
            swap_ack    <= swap_ack_d;
            // Indexed by the pre-edge back buffer, so a write on a swap edge
            // lands in the buffer that becomes front.
            if (wr_ok) begin
                bufs_q[~front_q][wr_row] <= wr_data;
            end
        end
    end

    assign cur_row = row_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with DWELL=16, BLANK=2 on an 8x8 matrix.
module tb_led_scan_ctrl;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DWELL = 16;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst, en, wr_en, swap_req;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_ack, frame_start;
    logic [7:0] row_sel, col;
    logic [2:0] cur_row;

    int n_vec  = 0;
    int n_fail = 0;
    string tag = "init";

    int pr = 0;
    int pc = 0;
    logic [7:0] disp [ROWS];

    typedef struct {
        logic       rst, en, wr_en;
        logic [2:0] wr_row;
        logic [7:0] wr_data;
        logic       swap_req;
        logic [7:0] rs, cl;
        logic [2:0] cr;
        logic       fs, ack;
    } vec_t;

    vec_t tbl [$];

    led_scan_ctrl #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DWELL(DWELL),
        .BLANK(BLANK)
    ) dut (
        .divided_clk(clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .row_sel    (row_sel),
        .col        (col),
        .cur_row    (cur_row),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h (row %0d cnt %0d)",
                     tag, name, got, exp, pr, pc);
        end
    endtask

    task automatic check_outs(input logic [7:0] rs, input logic [7:0] cl, input logic [2:0] cr,
                              input logic fs, input logic ack);
        check("row_sel", 32'(row_sel), 32'(rs));
        check("col", 32'(col), 32'(cl));
        check("cur_row", 32'(cur_row), 32'(cr));
        check("frame_start", 32'(frame_start), 32'(fs));
        check("swap_ack", 32'(swap_ack), 32'(ack));
    endtask

    // Advance the expected scan position by one cycle and compare.
    task automatic tick_check(input logic exp_ack);
        logic [7:0] ers, ecol;
        step();
        if (pc == DWELL - 1) begin
            pc = 0;
            pr = (pr == ROWS - 1) ? 0 : pr + 1;
        end else begin
            pc++;
        end
        ers  = (pc < BLANK) ? 8'h00 : 8'(1 << pr);
        ecol = (pc < BLANK) ? 8'h00 : disp[pr];
        check_outs(ers, ecol, 3'(pr), (pr == 0 && pc == 0), exp_ack);
    endtask

    task automatic run_to(input int r, input int c);
        int guard = 0;
        while (!(pr == r && pc == c) && guard < ROWS * DWELL) begin
            tick_check(1'b0);
            guard++;
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic we, input logic [2:0] wa,
                                input logic [7:0] wd, input logic sr, input logic [7:0] rs,
                                input logic [7:0] cl, input logic [2:0] cr, input logic fs,
                                input logic ack);
        vec_t v;
        v.rst = r; v.en = e; v.wr_en = we; v.wr_row = wa; v.wr_data = wd; v.swap_req = sr;
        v.rs = rs; v.cl = cl; v.cr = cr; v.fs = fs; v.ack = ack;
        return v;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;

        // rst en we  row data  sr    row_sel col  cur fs ack
        tbl.push_back(mk(1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h01, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h01, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
        for (int r = 0; r < ROWS; r++) begin
            tbl.push_back(mk(0, 0, 1, 3'(r), 8'(1 << r), 0, 8'h00, 8'h00, 0, 0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0));

        tag = "table";
        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; wr_en = tbl[i].wr_en;
            wr_row = tbl[i].wr_row; wr_data = tbl[i].wr_data; swap_req = tbl[i].swap_req;
            step();
            check_outs(tbl[i].rs, tbl[i].cl, tbl[i].cr, tbl[i].fs, tbl[i].ack);
        end

        // Two full frames of row timing from the first frame_start
        tag = "row_timing";
        pr = 0; pc = 0;
        for (int r = 0; r < ROWS; r++) disp[r] = 8'(1 << r);
        for (int i = 1; i < 2 * ROWS * DWELL; i++) tick_check(1'b0);

        // Mid-frame writes plus swap request; old data until the boundary
        tag = "boundary_swap";
        run_to(2, 5);
        for (int r = 0; r < ROWS; r++) begin
            wr_en = 1'b1; wr_row = 3'(r); wr_data = 8'hFF;
            tick_check(1'b0);
        end
        wr_en = 1'b0;
        swap_req = 1'b1;
        run_to(ROWS - 1, DWELL - 1);
        for (int r = 0; r < ROWS; r++) disp[r] = 8'hFF;
        tick_check(1'b1);
        swap_req = 1'b0;
        for (int i = 1; i < ROWS * DWELL; i++) tick_check(1'b0);

        // Drop en while row 3 is lit, then restart
        tag = "en_drop";
        run_to(3, 5);
        en = 1'b0;
        step();
        check_outs(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        check_outs(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        en = 1'b1;
        step();
        check_outs(8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        pr = 0; pc = 0;
        for (int i = 1; i < ROWS * DWELL; i++) tick_check(1'b0);

        // Write to row 0 on the same edge as the boundary swap
        tag = "collision";
        swap_req = 1'b1; wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hA5;
        disp[0] = 8'hA5;
        for (int r = 1; r < ROWS; r++) disp[r] = 8'(1 << r);
        tick_check(1'b1);
        swap_req = 1'b0; wr_en = 1'b0;
        for (int i = 1; i < ROWS * DWELL; i++) tick_check(1'b0);

        // Reset mid-frame with a swap pending; buffers come back blank
        tag = "reset_mid";
        run_to(3, 5);
        swap_req = 1'b1;
        for (int i = 0; i < 3; i++) tick_check(1'b0);
        rst = 1'b1; en = 1'b0;
        step();
        check_outs(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        swap_req = 1'b0;
        step();
        check_outs(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_outs(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        en = 1'b1;
        step();
        check_outs(8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        pr = 0; pc = 0;
        for (int r = 0; r < ROWS; r++) disp[r] = 8'h00;
        for (int i = 1; i <= ROWS * DWELL; i++) tick_check(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
